multicycle_main_control: RTL and testbench

- Main control FSM for the multi-cycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives every datapath enable and mux select, and produces the 2-bit ALUOp consumed by the downstream ALU control decoder.
- Stalls on memory accesses until the memory signals mem_ready.

---
 rtl/mips_ctrl_pkg.sv | 83 ++++++++
 rtl/main_ctrl_decode.sv | 65 ++++++
 rtl/multicycle_main_control.sv | 111 +++++++++++
 tb/tb_multicycle_main_control.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS main control FSM:
// opcodes, state encodings, ALU/mux select codes and the control bundle.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_RD    = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WR    = 4'd5,
        ST_EXEC      = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_ADDI_EXEC = 4'd10,
        ST_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_RTYPE = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_ADD   = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
    } ctrl_t;

    // Idle bundle: everything low except ALUOp, which rests at add.
    localparam ctrl_t CTRL_DEFAULT = '{
        pc_write:      1'b0,
        pc_write_cond: 1'b0,
        i_or_d:        1'b0,
        mem_read:      1'b0,
        mem_write:     1'b0,
        mem_to_reg:    1'b0,
        ir_write:      1'b0,
        pc_source:     PCSRC_ALU,
        alu_op:        ALUOP_ADD,
        alu_src_a:     1'b0,
        alu_src_b:     SRCB_REGB,
        reg_write:     1'b0,
        reg_dst:       1'b0
    };

    function automatic logic opcode_supported(input logic [5:0] op, input logic allow_addi);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
            OP_ADDI:                              ok = allow_addi;
            default:                              ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/main_ctrl_decode.sv
// Combinational map from the current FSM state (plus mem_ready, used only
// to gate the FETCH-cycle PC/IR loads) to the datapath control bundle.
module main_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    // Moore decode of state into control signals
    always_comb begin
        ctrl = CTRL_DEFAULT;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
            end
            ST_MEM_ADDR, ST_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            ST_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            ST_R_WB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            ST_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = CTRL_DEFAULT;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multi-cycle MIPS datapath: holds the state register,
// next-state sequencing with memory stalls, and the sticky illegal-opcode flag.
module multicycle_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALLOW_ADDI = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    localparam logic ADDI_EN = (ALLOW_ADDI != 0);

    state_t state_r;
    state_t next_state_s;
    logic   illegal_r;
    logic   decode_bad_s;
    ctrl_t  ctrl_s;

    assign decode_bad_s = (state_r == ST_DECODE) && !opcode_supported(opcode, ADDI_EN);

    // State register and sticky illegal flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_FETCH;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            illegal_r <= illegal_r | decode_bad_s;
        end
    end

    // Next-state sequencing; memory states hold until mem_ready
    always_comb begin
        next_state_s = ST_FETCH;
        case (state_r)
            ST_FETCH: begin
                if (mem_ready) next_state_s = ST_DECODE;
                else           next_state_s = ST_FETCH;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     next_state_s = ST_EXEC;
                    OP_LW, OP_SW: next_state_s = ST_MEM_ADDR;
                    OP_BEQ:       next_state_s = ST_BRANCH;
                    OP_J:         next_state_s = ST_JUMP;
                    OP_ADDI: begin
                        if (ADDI_EN) next_state_s = ST_ADDI_EXEC;
                        else         next_state_s = ST_FETCH;
                    end
                    default:      next_state_s = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR: begin
                if (opcode == OP_LW) next_state_s = ST_MEM_RD;
                else                 next_state_s = ST_MEM_WR;
            end
            ST_MEM_RD: begin
                if (mem_ready) next_state_s = ST_MEM_WB;
                else           next_state_s = ST_MEM_RD;
            end
            ST_MEM_WR: begin
                if (mem_ready) next_state_s = ST_FETCH;
                else           next_state_s = ST_MEM_WR;
            end
            ST_EXEC:      next_state_s = ST_R_WB;
            ST_ADDI_EXEC: next_state_s = ST_ADDI_WB;
            default:      next_state_s = ST_FETCH;
        endcase
    end

    main_ctrl_decode u_decode (
        .state     (state_r),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_s)
    );

    assign PCWrite     = ctrl_s.pc_write;
    assign PCWriteCond = ctrl_s.pc_write_cond;
    assign IorD        = ctrl_s.i_or_d;
    assign MemRead     = ctrl_s.mem_read;
    assign MemWrite    = ctrl_s.mem_write;
    assign MemtoReg    = ctrl_s.mem_to_reg;
    assign IRWrite     = ctrl_s.ir_write;
    assign PCSource    = ctrl_s.pc_source;
    assign ALUOp       = ctrl_s.alu_op;
    assign ALUSrcA     = ctrl_s.alu_src_a;
    assign ALUSrcB     = ctrl_s.alu_src_b;
    assign RegWrite    = ctrl_s.reg_write;
    assign RegDst      = ctrl_s.reg_dst;
    assign illegal_op  = illegal_r;
    assign state_o     = state_r;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Randomized instruction stream checked cycle by cycle against a path-level
// model of the main control FSM (expected state trace per instruction class).
module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic       ALUSrcA, RegWrite, RegDst, illegal_op;
    logic [3:0] state_o;

    int checks = 0;
    int failures = 0;
    logic exp_illegal = 1'b0;

    multicycle_main_control #(.ALLOW_ADDI(1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
        .RegDst(RegDst), .illegal_op(illegal_op), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected control word for a state, straight from the per-state output list
    function automatic logic [15:0] exp_out(input int st, input logic mr);
        logic pcw = 1'b0, pcwc = 1'b0, iord = 1'b0, mrd = 1'b0, mwr = 1'b0, m2r = 1'b0, irw = 1'b0;
        logic srca = 1'b0, rw = 1'b0, rd = 1'b0;
        logic [1:0] pcs = 2'b00, aop = 2'b10, srcb = 2'b00;
        case (st)
            0:  begin mrd = 1'b1; srcb = 2'b01; pcw = mr; irw = mr; end
            1:  srcb = 2'b11;
            2:  begin srca = 1'b1; srcb = 2'b10; end
            3:  begin mrd = 1'b1; iord = 1'b1; end
            4:  begin m2r = 1'b1; rw = 1'b1; end
            5:  begin mwr = 1'b1; iord = 1'b1; end
            6:  begin srca = 1'b1; aop = 2'b00; end
            7:  begin rd = 1'b1; rw = 1'b1; end
            8:  begin srca = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
            9:  begin pcw = 1'b1; pcs = 2'b10; end
            10: begin srca = 1'b1; srcb = 2'b10; end
            11: rw = 1'b1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, pcs, aop, srca, srcb, rw, rd};
    endfunction

    // Runs one instruction; sf/sm = stall cycles in FETCH / memory state.
    // reset_at >= 0 pulls rst_n low during that cycle of the trace and aborts.
    task automatic run_instr(input logic [5:0] op, input int sf, input int sm, input int reset_at);
        int  st_q[$];
        bit  mr_q[$];
        int  writes_exp = 0;
        int  writes_seen = 0;
        bit  bad;
        logic [15:0] obs;
        for (int j = 0; j < sf; j++) begin st_q.push_back(0); mr_q.push_back(1'b0); end
        st_q.push_back(0); mr_q.push_back(1'b1);
        st_q.push_back(1); mr_q.push_back(1'($urandom));
        bad = 1'b0;
        case (op)
            6'h23: begin
                st_q.push_back(2); mr_q.push_back(1'($urandom));
                for (int j = 0; j < sm; j++) begin st_q.push_back(3); mr_q.push_back(1'b0); end
                st_q.push_back(3); mr_q.push_back(1'b1);
                st_q.push_back(4); mr_q.push_back(1'($urandom));
                writes_exp = 1;
            end
            6'h2B: begin
                st_q.push_back(2); mr_q.push_back(1'($urandom));
                for (int j = 0; j < sm; j++) begin st_q.push_back(5); mr_q.push_back(1'b0); end
                st_q.push_back(5); mr_q.push_back(1'b1);
            end
            6'h00: begin
                st_q.push_back(6); mr_q.push_back(1'($urandom));
                st_q.push_back(7); mr_q.push_back(1'($urandom));
                writes_exp = 1;
            end
            6'h04: begin st_q.push_back(8); mr_q.push_back(1'($urandom)); end
            6'h02: begin st_q.push_back(9); mr_q.push_back(1'($urandom)); end
            6'h08: begin
                st_q.push_back(10); mr_q.push_back(1'($urandom));
                st_q.push_back(11); mr_q.push_back(1'($urandom));
                writes_exp = 1;
            end
            default: bad = 1'b1;
        endcase
        for (int i = 0; i < st_q.size(); i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            opcode = op;
            mem_ready = mr_q[i];
            #1;
            obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                   PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst};
            check($sformatf("state op=%02h cyc=%0d", op, i), 32'(state_o), 32'(st_q[i]));
            check($sformatf("ctrl op=%02h st=%0d mr=%0d", op, st_q[i], mr_q[i]),
                  32'(obs), 32'(exp_out(st_q[i], mr_q[i])));
            check($sformatf("illegal_op op=%02h cyc=%0d", op, i), 32'(illegal_op), 32'(exp_illegal));
            check("mem_rd_wr_exclusive", 32'(MemRead & MemWrite), 32'd0);
            if (RegWrite === 1'b1) writes_seen++;
            if (i == reset_at) begin
                rst_n = 1'b0;
                exp_illegal = 1'b0;
                return;
            end
            if (st_q[i] == 1 && bad) exp_illegal = 1'b1;
        end
        check($sformatf("regwrite_count op=%02h", op), 32'(writes_seen), 32'(writes_exp));
    endtask

    initial begin
        logic [5:0] op;
        int k;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        opcode = 6'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_state", 32'(state_o), 32'd0);
        check("reset_memread", 32'(MemRead), 32'd1);
        check("reset_irwrite", 32'(IRWrite), 32'd1);
        check("reset_aluop", 32'(ALUOp), 32'd2);
        check("reset_illegal", 32'(illegal_op), 32'd0);

        // directed: latencies with no stalls, then stalls in FETCH and MEM_WR
        run_instr(6'h23, 0, 0, -1);
        run_instr(6'h00, 0, 0, -1);
        run_instr(6'h04, 0, 0, -1);
        run_instr(6'h02, 0, 0, -1);
        run_instr(6'h08, 0, 0, -1);
        run_instr(6'h2B, 2, 3, -1);
        run_instr(6'h3F, 0, 0, -1);
        run_instr(6'h00, 1, 0, -1);

        // reset while MEM_RD is stalled (trace index 3 is MEM_RD)
        run_instr(6'h23, 0, 2, 3);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("midop_reset_state", 32'(state_o), 32'd0);
        check("midop_reset_illegal", 32'(illegal_op), 32'd0);
        check("midop_reset_memwrite", 32'(MemWrite), 32'd0);
        check("fetch_stall_pcwrite", 32'(PCWrite), 32'd0);

        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 6);
            case (k)
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h04;
                4: op = 6'h02;
                5: op = 6'h08;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    if (op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
                        op == 6'h02 || op == 6'h08) op = 6'h3F;
                end
            endcase
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
